// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, REQ, FILL, REPLAY} state_t;

  function automatic int off_w(input int line_words);
    return $clog2(line_words * 4);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_words, input int sets);
    return 32 - off_w(line_words) - idx_w(sets);
  endfunction

  function automatic int beats(input int line_words, input int mem_w);
    return (line_words * 32) / mem_w;
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: tag RAM, valid flops and beat-wide data RAM with one
// registered lookup port and one beat-write port.
module icache_way
  import icache_pkg::*;
#(
  parameter int SETS   = 64,
  parameter int BEATS  = 1,
  parameter int MEM_W  = 128,
  parameter int TAG_W  = 22,
  parameter int IDX_W  = 6,
  parameter int BEAT_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IDX_W-1:0]  rd_index,
  input  logic [BEAT_W-1:0] rd_beat,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [MEM_W-1:0]  rd_data,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic              wr_set_valid,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [BEAT_W-1:0] wr_beat,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [MEM_W-1:0]  wr_data
);

  localparam int BSEL_W = $clog2(BEATS);
  localparam int DA_W   = IDX_W + BSEL_W;

  logic [MEM_W-1:0] data_mem [SETS*BEATS];
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [SETS-1:0]  valid_reg;
  logic [DA_W-1:0]  rd_addr;
  logic [DA_W-1:0]  wr_addr;

  generate
    if (BEATS > 1) begin : g_multi
      assign rd_addr = {rd_index, rd_beat};
      assign wr_addr = {wr_index, wr_beat};
    end else begin : g_single
      logic unused_beat;
      assign unused_beat = ^{rd_beat, wr_beat};
      assign rd_addr     = rd_index;
      assign wr_addr     = wr_index;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wr_en)
      data_mem[wr_addr] <= wr_data;
    rd_data <= data_mem[rd_addr];
  end

  // Tag is committed together with the valid bit on the final beat.
  always_ff @(posedge clk) begin
    if (wr_en && wr_last)
      tag_mem[wr_index] <= wr_tag;
    rd_tag <= tag_mem[rd_index];
  end

  // A lookup issued in the flush cycle must already see the set as empty.
  always_ff @(posedge clk) begin
    if (rst || flush)
      valid_reg <= '0;
    else if (wr_en && wr_last)
      valid_reg[wr_index] <= wr_set_valid;
    if (rst)
      rd_valid <= 1'b0;
    else
      rd_valid <= valid_reg[rd_index] & ~flush;
  end

endmodule

// File: rtl/icache_assoc.sv
// N-way set-associative instruction cache with round-robin replacement and flush.
// Optional ICACHE_PERF_EN adds saturating hit/miss counters.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int MEM_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      icache_addr,
  input  logic             icache_re,
  output logic [31:0]      instruction,
  output logic             stall,
  input  logic             flush,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [31:0]      mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [MEM_W-1:0] mem_resp_data
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0]      perf_hits,
  output logic [31:0]      perf_misses
`endif
);

  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(LINE_WORDS, SETS);
  localparam int BEATS  = beats(LINE_WORDS, MEM_W);
  localparam int BEAT_W = cnt_w(BEATS);
  localparam int WOFF_W = $clog2(LINE_WORDS);
  localparam int WPB    = MEM_W / 32;
  localparam int WPB_W  = $clog2(WPB);
  localparam int WAY_W  = cnt_w(WAYS);

  // Address helpers operate on word addresses (byte address >> 2).
  function automatic logic [IDX_W-1:0] index_of(input logic [29:0] w);
    return IDX_W'(w >> WOFF_W);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [29:0] w);
    return TAG_W'(w >> (WOFF_W + IDX_W));
  endfunction

  function automatic logic [BEAT_W-1:0] beat_of(input logic [29:0] w);
    return BEAT_W'((w >> WPB_W) & 30'(BEATS - 1));
  endfunction

  function automatic logic [31:0] word_sel(input logic [MEM_W-1:0] data, input logic [29:0] w);
    return 32'(data >> {w & 30'(WPB - 1), 5'b00000});
  endfunction

  state_t             state_reg, state_next;
  logic               lookup_reg;
  logic               accept;
  logic [29:0]        req_word_reg;
  logic [31:0]        inst_hold_reg;
  logic [31:0]        fill_word_reg;
  logic [BEAT_W-1:0]  beat_cnt_reg;
  logic               fill_kill_reg;
  logic [WAY_W-1:0]   victim_reg;
  logic [WAY_W-1:0]   victim_sel;
  logic [WAYS-1:0]    way_valid;
  logic [WAYS-1:0]    hit_vec;
  logic [TAG_W-1:0]   way_tag  [WAYS];
  logic [MEM_W-1:0]   way_data [WAYS];
  logic               hit;
  logic [MEM_W-1:0]   hit_data;
  logic               miss_detect;
  logic               fill_beat;
  logic               fill_last;
  logic [IDX_W-1:0]   req_index;
  logic [TAG_W-1:0]   req_tag;
  logic               unused_addr;

  assign unused_addr = ^icache_addr[1:0];
  assign req_index   = index_of(req_word_reg);
  assign req_tag     = tag_of(req_word_reg);
  assign fill_beat   = (state_reg == FILL) && mem_resp_valid;
  assign fill_last   = (beat_cnt_reg == BEAT_W'(BEATS - 1));
  assign miss_detect = (state_reg == IDLE) && lookup_reg && !hit;
  assign mem_req_addr = {req_word_reg, 2'b00} & ~(32'(LINE_WORDS * 4) - 32'd1);

  generate
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
      icache_way #(
        .SETS(SETS), .BEATS(BEATS), .MEM_W(MEM_W),
        .TAG_W(TAG_W), .IDX_W(IDX_W), .BEAT_W(BEAT_W)
      ) u_way (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .rd_index     (index_of(icache_addr[31:2])),
        .rd_beat      (beat_of(icache_addr[31:2])),
        .rd_valid     (way_valid[gi]),
        .rd_tag       (way_tag[gi]),
        .rd_data      (way_data[gi]),
        .wr_en        (fill_beat && (victim_reg == WAY_W'(gi))),
        .wr_last      (fill_last),
        .wr_set_valid (!fill_kill_reg),
        .wr_index     (req_index),
        .wr_beat      (beat_cnt_reg),
        .wr_tag       (req_tag),
        .wr_data      (mem_resp_data)
      );
      assign hit_vec[gi] = way_valid[gi] && (way_tag[gi] == req_tag);
    end
  endgenerate

  // Walk downwards so the lowest hitting way takes priority.
  always_comb begin
    hit      = 1'b0;
    hit_data = way_data[0];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) begin
        hit      = 1'b1;
        hit_data = way_data[w];
      end
    end
  end

  generate
    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] ptr_reg [SETS];
      logic             inv_found;

      always_comb begin
        victim_sel = ptr_reg[req_index];
        inv_found  = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
          if (!way_valid[w]) begin
            victim_sel = WAY_W'(w);
            inv_found  = 1'b1;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst || flush) begin
          for (int s = 0; s < SETS; s++)
            ptr_reg[s] <= '0;
        end else if (miss_detect && !inv_found) begin
          ptr_reg[req_index] <= ptr_reg[req_index] + WAY_W'(1);
        end
      end
    end else begin : g_dm
      assign victim_sel = '0;
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    stall         = 1'b0;
    mem_req_valid = 1'b0;
    accept        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (miss_detect) begin
          stall      = 1'b1;
          state_next = REQ;
        end else begin
          accept = icache_re;
        end
      end
      REQ: begin
        stall         = 1'b1;
        mem_req_valid = 1'b1;
        if (mem_req_ready)
          state_next = FILL;
      end
      FILL: begin
        stall = 1'b1;
        if (fill_beat && fill_last)
          state_next = REPLAY;
      end
      REPLAY: begin
        accept     = icache_re;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    if (state_reg == REPLAY)
      instruction = fill_word_reg;
    else if ((state_reg == IDLE) && lookup_reg && hit)
      instruction = word_sel(hit_data, req_word_reg);
    else
      instruction = inst_hold_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      lookup_reg    <= 1'b0;
      req_word_reg  <= '0;
      inst_hold_reg <= '0;
      fill_word_reg <= '0;
      beat_cnt_reg  <= '0;
      fill_kill_reg <= 1'b0;
      victim_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      lookup_reg    <= accept;
      inst_hold_reg <= instruction;
      if (accept)
        req_word_reg <= icache_addr[31:2];
      // A flush seen anywhere during the refill keeps the new line invalid.
      if (miss_detect) begin
        victim_reg    <= victim_sel;
        fill_kill_reg <= flush;
        beat_cnt_reg  <= '0;
      end else if (state_reg != IDLE) begin
        fill_kill_reg <= fill_kill_reg | flush;
      end
      if (fill_beat) begin
        beat_cnt_reg <= fill_last ? '0 : beat_cnt_reg + BEAT_W'(1);
        if (beat_cnt_reg == beat_of(req_word_reg))
          fill_word_reg <= word_sel(mem_resp_data, req_word_reg);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && lookup_reg && (state_reg == IDLE))
      assert ($onehot0(hit_vec));
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hits_reg;
  logic [31:0] misses_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else begin
      if ((state_reg == IDLE) && lookup_reg && hit && (hits_reg != 32'hFFFF_FFFF))
        hits_reg <= hits_reg + 32'd1;
      if (miss_detect && (misses_reg != 32'hFFFF_FFFF))
        misses_reg <= misses_reg + 32'd1;
    end
  end

  assign perf_hits   = hits_reg;
  assign perf_misses = misses_reg;
`endif

endmodule
